// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline request/response and data-memory bus bundle for mem_access_unit
interface mem_access_unit_if;
    logic        ReqValid;
    logic        ReqLoad;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWdata;
    logic        Stall;
    logic        Done;
    logic [31:0] RespData;
    logic        MisalignErr;
    logic        RangeErr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] Wdata;
    logic [31:0] Rdata;

    modport slave (
        input  ReqValid, ReqLoad, ReqSize, ReqSigned, ReqAddr, ReqWdata, Rdata,
        output Stall, Done, RespData, MisalignErr, RangeErr, MemRead, MemWrite, Addr, Wdata
    );

    modport master (
        output ReqValid, ReqLoad, ReqSize, ReqSigned, ReqAddr, ReqWdata, Rdata,
        input  Stall, Done, RespData, MisalignErr, RangeErr, MemRead, MemWrite, Addr, Wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store initiator with read-modify-write; MEM_BOUNDS_CHECK_EN enables range rejection
module mem_access_unit #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    load_q, load_d;
    logic [1:0]              size_q, size_d;
    logic                    signed_q, signed_d;
    logic [DEPTH_LOG2+1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             resp_q, resp_d;
    logic                    mis_q, mis_d;
    logic                    rng_q, rng_d;

    logic                    misalign;
    logic                    out_of_range;
    logic [31:0]             load_val;
    logic [31:0]             merged;
    logic [7:0]              lane_b;
    logic [15:0]             lane_h;
    logic                    mem_read;
    logic                    mem_write;
    logic [31:0]             wdata_out;

    assign misalign = (bus.ReqSize == 2'b11)
                    | ((bus.ReqSize == 2'b01) & bus.ReqAddr[0])
                    | ((bus.ReqSize == 2'b10) & (|bus.ReqAddr[1:0]));

`ifdef MEM_BOUNDS_CHECK_EN
    assign out_of_range = |bus.ReqAddr[31:DEPTH_LOG2+2];
`else
    // Upper address bits wrap modulo the memory depth.
    logic addr_hi_unused;
    assign addr_hi_unused = ^bus.ReqAddr[31:DEPTH_LOG2+2];
    assign out_of_range   = 1'b0;
`endif

    always_comb begin
        lane_b   = bus.Rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = bus.Rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = {{24{signed_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_val = bus.Rdata;
        endcase
    end

    always_comb begin
        merged = rdata_q;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        size_d    = size_q;
        signed_d  = signed_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        mis_d     = mis_q;
        rng_d     = rng_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wdata_out = 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.ReqValid) begin
                    load_d   = bus.ReqLoad;
                    size_d   = bus.ReqSize;
                    signed_d = bus.ReqSigned;
                    addr_d   = bus.ReqAddr[DEPTH_LOG2+1:0];
                    wdata_d  = bus.ReqWdata;
                    resp_d   = 32'h0;
                    mis_d    = misalign;
                    rng_d    = ~misalign & out_of_range;
                    state_d  = (misalign | out_of_range) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (load_q || size_q != 2'b10) begin
                    mem_read = 1'b1;
                    rdata_d  = bus.Rdata;
                    if (load_q) begin
                        resp_d  = load_val;
                        state_d = DONE;
                    end else begin
                        state_d = RMW_WR;
                    end
                end else begin
                    mem_write = 1'b1;
                    wdata_out = wdata_q;
                    state_d   = DONE;
                end
            end
            RMW_WR: begin
                mem_write = 1'b1;
                wdata_out = merged;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            load_q   <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            resp_q   <= 32'h0;
            mis_q    <= 1'b0;
            rng_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
            mis_q    <= mis_d;
            rng_q    <= rng_d;
        end
    end

    assign bus.Done        = (state_q == DONE);
    assign bus.Stall       = bus.ReqValid & ~bus.Done;
    assign bus.RespData    = (bus.Done & load_q) ? resp_q : 32'h0;
    assign bus.MisalignErr = bus.Done & mis_q;
    assign bus.RangeErr    = bus.Done & rng_q;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.Wdata       = wdata_out;
    assign bus.Addr        = {{(32-DEPTH_LOG2){1'b0}}, addr_q[DEPTH_LOG2+1:2]};
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a word memory model
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_access_unit_if mif();

    mem_access_unit #(.DEPTH_LOG2(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:511];
    logic [31:0] ref_mem [0:511];

    assign mif.Rdata = mif.MemRead ? mem[mif.Addr[8:0]] : 32'h0;
    always @(posedge clk) if (mif.MemWrite) mem[mif.Addr[8:0]] <= mif.Wdata;

    typedef struct {
        logic [31:0] resp;
        logic        mis;
        logic        rng;
        int          lat;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] addr;
        logic [31:0] wword;
        logic        ld;
    } exp_t;

    exp_t sb[$];

    task automatic model_op(input logic ld, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        logic [8:0]  idx;
        logic [31:0] w, sh, mask, nw;
        int          off;
        idx = a[10:2];
        e.ld = ld; e.addr = {23'b0, idx}; e.resp = 32'h0; e.rd_cyc = 0; e.wr_cyc = 0; e.wword = 32'h0;
        e.mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`ifdef MEM_BOUNDS_CHECK_EN
        e.rng = !e.mis && (a[31:11] != 21'h0);
`else
        e.rng = 1'b0;
`endif
        if (e.mis || e.rng) begin
            e.lat = 1;
        end else if (ld) begin
            w = ref_mem[idx];
            e.rd_cyc = 1; e.lat = 2;
            if (sz == 2'b00) begin
                sh = w >> (a[1:0] * 8);
                e.resp = {24'h0, sh[7:0]};
                if (sg && sh[7]) e.resp = e.resp | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                sh = w >> (a[1] ? 16 : 0);
                e.resp = {16'h0, sh[15:0]};
                if (sg && sh[15]) e.resp = e.resp | 32'hFFFF_0000;
            end else begin
                e.resp = w;
            end
        end else if (sz == 2'b10) begin
            ref_mem[idx] = wd;
            e.wword = wd; e.wr_cyc = 1; e.lat = 2;
        end else begin
            off  = (sz == 2'b00) ? a[1:0] * 8 : (a[1] ? 16 : 0);
            mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << off;
            nw   = (ref_mem[idx] & ~mask) | ((wd << off) & mask);
            ref_mem[idx] = nw;
            e.wword = nw; e.rd_cyc = 1; e.wr_cyc = 2; e.lat = 3;
        end
    endtask

    // Entered at a falling edge; returns at the falling edge of the Done cycle.
    task automatic run_op(input string name, input logic ld, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic drop_valid);
        exp_t        e, x;
        int          n, rd_n, wr_n, rd_c, wr_c, lat;
        logic        done_seen, both, stall_bad, mis_o, rng_o, stall_o;
        logic [31:0] addr_rd, addr_wr, wdata_w, resp_o;
        model_op(ld, sz, sg, a, wd, e);
        sb.push_back(e);
        mif.ReqValid = 1'b1; mif.ReqLoad = ld; mif.ReqSize = sz; mif.ReqSigned = sg;
        mif.ReqAddr = a; mif.ReqWdata = wd;
        if (mif.Done) begin
            @(negedge clk);
            checks++;
            if (mif.Stall !== 1'b1 || mif.Done !== 1'b0) begin
                failures++;
                $display("FAIL %s b2b_idle: stall=%b done=%b required stall=1 done=0", name, mif.Stall, mif.Done);
            end
        end
        n = 0; rd_n = 0; wr_n = 0; rd_c = 0; wr_c = 0; lat = 0;
        done_seen = 0; both = 0; stall_bad = 0;
        addr_rd = 0; addr_wr = 0; wdata_w = 0; resp_o = 0; mis_o = 0; rng_o = 0; stall_o = 0;
        while (n < 8 && !done_seen) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                mif.ReqLoad = 1'($urandom); mif.ReqSize = 2'($urandom); mif.ReqSigned = 1'($urandom);
                mif.ReqAddr = $urandom; mif.ReqWdata = $urandom;
                if (drop_valid) mif.ReqValid = 1'b0;
            end
            if (mif.MemRead && mif.MemWrite) both = 1;
            if (mif.MemRead) begin rd_n++; if (rd_c == 0) begin rd_c = n; addr_rd = mif.Addr; end end
            if (mif.MemWrite) begin wr_n++; if (wr_c == 0) begin wr_c = n; addr_wr = mif.Addr; wdata_w = mif.Wdata; end end
            if (mif.Done) begin
                done_seen = 1; lat = n; resp_o = mif.RespData;
                mis_o = mif.MisalignErr; rng_o = mif.RangeErr; stall_o = mif.Stall;
            end else if (!drop_valid && mif.Stall !== 1'b1) begin
                stall_bad = 1;
            end
        end
        mif.ReqValid = 1'b0;
        x = sb.pop_front();
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL %s timeout: no Done within 8 cycles, required Done at cycle %0d", name, x.lat);
        end else if (lat != x.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, x.lat);
        end
        checks++;
        if (mis_o !== x.mis || rng_o !== x.rng) begin
            failures++;
            $display("FAIL %s errflags: misalign=%b range=%b required %b %b", name, mis_o, rng_o, x.mis, x.rng);
        end
        if (x.ld || x.mis || x.rng) begin
            checks++;
            if (resp_o !== x.resp) begin
                failures++;
                $display("FAIL %s respdata: got %h required %h", name, resp_o, x.resp);
            end
        end
        checks++;
        if (rd_n != (x.rd_cyc != 0 ? 1 : 0) || rd_c != x.rd_cyc || wr_n != (x.wr_cyc != 0 ? 1 : 0) || wr_c != x.wr_cyc) begin
            failures++;
            $display("FAIL %s strobes: read n=%0d@%0d write n=%0d@%0d required read@%0d write@%0d",
                     name, rd_n, rd_c, wr_n, wr_c, x.rd_cyc, x.wr_cyc);
        end
        checks++;
        if (both || stall_bad || stall_o !== 1'b0) begin
            failures++;
            $display("FAIL %s stall_excl: both=%b stall_bad=%b stall_at_done=%b required 0 0 0", name, both, stall_bad, stall_o);
        end
        if (x.rd_cyc != 0) begin
            checks++;
            if (addr_rd !== x.addr) begin
                failures++;
                $display("FAIL %s read_addr: got %h required %h", name, addr_rd, x.addr);
            end
        end
        if (x.wr_cyc != 0) begin
            checks++;
            if (addr_wr !== x.addr || wdata_w !== x.wword || mem[x.addr[8:0]] !== ref_mem[x.addr[8:0]]) begin
                failures++;
                $display("FAIL %s write: addr=%h wdata=%h mem=%h required addr=%h wdata=%h",
                         name, addr_wr, wdata_w, mem[x.addr[8:0]], x.addr, x.wword);
            end
        end
    endtask

    task automatic test_reset();
        mif.ReqValid = 0; mif.ReqLoad = 0; mif.ReqSize = 0; mif.ReqSigned = 0; mif.ReqAddr = 0; mif.ReqWdata = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mif.Done, mif.Stall, mif.MemRead, mif.MemWrite, mif.MisalignErr, mif.RangeErr} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000000",
                     {mif.Done, mif.Stall, mif.MemRead, mif.MemWrite, mif.MisalignErr, mif.RangeErr});
        end
        checks++;
        if (mif.Addr !== 32'h0 || mif.Wdata !== 32'h0 || mif.RespData !== 32'h0) begin
            failures++;
            $display("FAIL reset_buses: addr=%h wdata=%h resp=%h required all 0", mif.Addr, mif.Wdata, mif.RespData);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_ops();
        run_op("st_w_deadbeef", 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        run_op("ld_w_10",       1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        run_op("st_w_0",        1'b0, 2'b10, 1'b0, 32'h0,  32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_subword_store();
        run_op("st_w_11223344", 1'b0, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0);
        run_op("st_b_a5_12",    1'b0, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFA5, 1'b0);
        checks++;
        if (mem[4] !== 32'h11A5_3344) begin
            failures++;
            $display("FAIL rmw_word: got %h required 11a53344", mem[4]);
        end
        run_op("st_h_8001_16",  1'b0, 2'b01, 1'b0, 32'h16, 32'h0000_8001, 1'b0);
        run_op("st_b_7f_14",    1'b0, 2'b00, 1'b0, 32'h14, 32'h0000_007F, 1'b0);
    endtask

    task automatic test_subword_loads();
        run_op("ld_bs_12", 1'b1, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0);
        run_op("ld_bu_12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0);
        run_op("ld_hs_12", 1'b1, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
        run_op("ld_hs_16", 1'b1, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0);
        run_op("ld_hu_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0);
        run_op("ld_bs_14", 1'b1, 2'b00, 1'b1, 32'h14, 32'h0, 1'b0);
        run_op("ld_bs_13", 1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
    endtask

    task automatic test_errors();
        run_op("ld_h_13_mis", 1'b1, 2'b01, 1'b1, 32'h13, 32'h0, 1'b0);
        run_op("st_w_02_mis", 1'b0, 2'b10, 1'b0, 32'h02, 32'h1234_5678, 1'b0);
        run_op("size11_mis",  1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
        run_op("st_w_802_mis", 1'b0, 2'b10, 1'b0, 32'h802, 32'h5555_AAAA, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_st_drop", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0000_00C3, 1'b1);
        run_op("b2b_ld_drop", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op("b2b_rand_st", 1'b0, 2'(i % 2), 1'b0, 32'h40 + 32'(i * 3) - 32'(i % 2 ? (i * 3) % 2 : 0), $urandom, 1'b0);
            run_op("b2b_rand_ld", 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        end
    endtask

    task automatic test_bounds();
        run_op("ld_w_800", 1'b1, 2'b10, 1'b0, 32'h800, 32'h0, 1'b0);
        run_op("st_w_1800", 1'b0, 2'b10, 1'b0, 32'h1804, 32'h0BAD_0BAD, 1'b0);
        run_op("ld_w_4", 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] saved;
        logic        done_seen, wr_seen;
        @(negedge clk);
        saved = mem[4];
        mif.ReqValid = 1'b1; mif.ReqLoad = 1'b0; mif.ReqSize = 2'b00; mif.ReqSigned = 1'b0;
        mif.ReqAddr = 32'h11; mif.ReqWdata = 32'h77;
        @(negedge clk);
        checks++;
        if (mif.MemRead !== 1'b1) begin
            failures++;
            $display("FAIL rst_rmw_access: MemRead=%b required 1", mif.MemRead);
        end
        reset = 1'b1;
        mif.ReqValid = 1'b0;
        #1;
        checks++;
        if (mif.MemRead !== 1'b0 || mif.MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL rst_rmw_strobes: MemRead=%b MemWrite=%b required 0 0", mif.MemRead, mif.MemWrite);
        end
        done_seen = 0; wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b0;
            if (mif.Done) done_seen = 1;
            if (mif.MemWrite || mif.MemRead) wr_seen = 1;
        end
        checks++;
        if (done_seen || wr_seen || mem[4] !== saved || mem[4] !== ref_mem[4]) begin
            failures++;
            $display("FAIL rst_rmw_after: done=%b strobe=%b mem=%h required done=0 strobe=0 mem=%h", done_seen, wr_seen, mem[4], saved);
        end
        run_op("ld_after_rst", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_ops();
        test_subword_store();
        test_subword_loads();
        test_errors();
        test_back_to_back();
        test_bounds();
        test_reset_mid_rmw();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
